// File: rtl/delay_event_scheduler.sv
// Two game-over requesters share one down-counter through a round-robin arbiter.
// Each granted request yields a one-cycle done strobe a fixed number of cycles later.
module delay_event_scheduler #(
   parameter int DELAY0 = 30,
   parameter int DELAY1 = 60,
   parameter int CNT_W  = 8
) (
   input  logic             clock_50,
   input  logic             reset_button,
   input  logic             clear,
   input  logic             game_over2,
   input  logic             game_over3,
   output logic [1:0]       done,
   output logic             busy,
   output logic [1:0]       pending,
   output logic             active_ch,
   output logic [1:0]       dropped,
   output logic [CNT_W-1:0] count
);

   typedef enum logic {IDLE, COUNT} state_t;

   // Loaded value is DELAY-1 because the grant edge itself is one cycle of the delay.
   localparam logic [CNT_W-1:0] LOAD0 = CNT_W'(DELAY0 - 1);
   localparam logic [CNT_W-1:0] LOAD1 = CNT_W'(DELAY1 - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   state_t           state, state_n;
   logic [1:0]       prev;
   logic [1:0]       req;
   logic [1:0]       pending_n, dropped_n, done_n;
   logic [CNT_W-1:0] count_n;
   logic             rr, rr_n;
   logic             active_n;
   logic             grant;
   logic             win;

   assign req  = {game_over3, game_over2} & ~prev;
   assign busy = (state == COUNT);

   always_ff @(posedge clock_50 or posedge reset_button) begin
      if (reset_button) begin
         state     <= IDLE;
         prev      <= '0;
         pending   <= '0;
         dropped   <= '0;
         done      <= '0;
         count     <= '0;
         active_ch <= 1'b0;
         rr        <= 1'b0;
      end else begin
         state     <= state_n;
         prev      <= {game_over3, game_over2};
         pending   <= pending_n;
         dropped   <= dropped_n;
         done      <= done_n;
         count     <= count_n;
         active_ch <= active_n;
         rr        <= rr_n;
      end
   end

   always_comb begin
      state_n   = state;
      count_n   = count;
      pending_n = pending;
      dropped_n = dropped;
      active_n  = active_ch;
      rr_n      = rr;
      done_n    = '0;
      grant     = 1'b0;
      win       = (pending == 2'b11) ? rr : pending[1];

      case (state)
         IDLE: grant = |pending;
         COUNT: begin
            if (count != '0) begin
               count_n = count - ONE;
            end else begin
               done_n[active_ch] = 1'b1;
               grant             = |pending;
               if (!(|pending)) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (grant) begin
         state_n        = COUNT;
         count_n        = win ? LOAD1 : LOAD0;
         active_n       = win;
         rr_n           = ~win;
         pending_n[win] = 1'b0;
      end

      // A new edge on an already-pending channel merges into it and is flagged.
      dropped_n = dropped_n | (req & pending);
      pending_n = pending_n | req;

      if (clear) begin
         state_n   = IDLE;
         count_n   = '0;
         pending_n = '0;
         dropped_n = '0;
         done_n    = '0;
         active_n  = active_ch;
         rr_n      = rr;
      end
   end

endmodule

// File: tb/tb_delay_event_scheduler.sv
// Bench for delay_event_scheduler: directed scenarios plus randomized traffic
// compared against a time-stamp based reference model.
module tb_delay_event_scheduler;

   localparam int D0 = 30;
   localparam int D1 = 60;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic          go2 = 1'b0;
   logic          go3 = 1'b0;
   logic [1:0]    done;
   logic          busy;
   logic [1:0]    pending;
   logic          active_ch;
   logic [1:0]    dropped;
   logic [CW-1:0] count;

   int tests_run = 0;
   int fails     = 0;

   delay_event_scheduler #(.DELAY0(D0), .DELAY1(D1), .CNT_W(CW)) dut (
      .clock_50    (clk),
      .reset_button(rst),
      .clear       (clr),
      .game_over2  (go2),
      .game_over3  (go3),
      .done        (done),
      .busy        (busy),
      .pending     (pending),
      .active_ch   (active_ch),
      .dropped     (dropped),
      .count       (count)
   );

   always #5 clk = ~clk;

   // Reference model: tracks the absolute edge at which the running delay expires.
   int         ecount = 0;
   int         m_exp  = 0;
   logic [1:0] m_prev = '0, m_pend = '0, m_drop = '0, m_done = '0;
   logic       m_busy = 1'b0, m_act = 1'b0, m_rr = 1'b0;

   initial begin
      logic [1:0] r, pb, inp;
      logic       g;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            ecount = 0; m_prev = '0; m_pend = '0; m_drop = '0; m_done = '0;
            m_busy = 1'b0; m_act = 1'b0; m_rr = 1'b0; m_exp = 0;
         end else begin
            ecount++;
            inp    = {go3, go2};
            r      = inp & ~m_prev;
            m_prev = inp;
            m_done = '0;
            if (clr) begin
               m_pend = '0; m_drop = '0; m_busy = 1'b0;
            end else begin
               pb = m_pend;
               if (m_busy && ecount == m_exp) begin
                  m_done[m_act] = 1'b1;
                  m_busy        = 1'b0;
               end
               if (!m_busy && pb != 2'b00) begin
                  g         = (pb == 2'b11) ? m_rr : pb[1];
                  m_busy    = 1'b1;
                  m_act     = g;
                  m_exp     = ecount + (g ? D1 : D0);
                  m_rr      = ~g;
                  m_pend[g] = 1'b0;
               end
               m_drop = m_drop | (r & pb);
               m_pend = m_pend | r;
            end
         end
      end
   end

   function automatic logic [CW-1:0] m_count();
      return m_busy ? CW'(m_exp - ecount - 1) : '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; go2 = 1'b0; go3 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      tests_run++;
      if ({done, busy, pending, active_ch, dropped, count} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got done=%b busy=%b pend=%b act=%b drop=%b cnt=%0d, want all 0",
                  done, busy, pending, active_ch, dropped, count);
      end
      do_reset();
      tests_run++;
      if ({done, busy, pending, count} !== '0) begin
         fails++;
         $display("FAIL reset_idle: got done=%b busy=%b pend=%b cnt=%0d, want all 0", done, busy, pending, count);
      end
   endtask

   task automatic test_single();
      do_reset();
      go2 = 1'b1; tick();
      tests_run++;
      if (pending !== 2'b01 || busy !== 1'b0) begin
         fails++;
         $display("FAIL single_req: pend=%b busy=%b, want 01 0", pending, busy);
      end
      go2 = 1'b0; tick();
      tests_run++;
      if (busy !== 1'b1 || count !== CW'(29) || active_ch !== 1'b0 || pending !== 2'b00) begin
         fails++;
         $display("FAIL single_grant: busy=%b cnt=%0d act=%b pend=%b, want 1 29 0 00", busy, count, active_ch, pending);
      end
      repeat (29) tick();
      tests_run++;
      if (done !== 2'b00 || count !== '0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL single_before_done: done=%b cnt=%0d busy=%b, want 00 0 1", done, count, busy);
      end
      tick();
      tests_run++;
      if (done !== 2'b01 || busy !== 1'b0) begin
         fails++;
         $display("FAIL single_done: done=%b busy=%b, want 01 0", done, busy);
      end
      tick();
      tests_run++;
      if (done !== 2'b00) begin
         fails++;
         $display("FAIL single_done_width: done=%b, want 00", done);
      end
   endtask

   task automatic test_both();
      do_reset();
      go2 = 1'b1; go3 = 1'b1; tick();
      go2 = 1'b0; go3 = 1'b0; tick();
      tests_run++;
      if (active_ch !== 1'b0 || count !== CW'(29) || pending !== 2'b10 || busy !== 1'b1) begin
         fails++;
         $display("FAIL both_first_grant: act=%b cnt=%0d pend=%b busy=%b, want 0 29 10 1", active_ch, count, pending, busy);
      end
      repeat (30) tick();
      tests_run++;
      if (done !== 2'b01 || busy !== 1'b1 || active_ch !== 1'b1 || count !== CW'(59) || pending !== 2'b00) begin
         fails++;
         $display("FAIL both_handover: done=%b busy=%b act=%b cnt=%0d pend=%b, want 01 1 1 59 00",
                  done, busy, active_ch, count, pending);
      end
      repeat (60) tick();
      tests_run++;
      if (done !== 2'b10 || busy !== 1'b0) begin
         fails++;
         $display("FAIL both_second_done: done=%b busy=%b, want 10 0", done, busy);
      end
   endtask

   task automatic test_dropped();
      int d1_n = 0, d1_a = -1, d1_b = -1, d0_at = -1;
      do_reset();
      go2 = 1'b1; tick();
      go2 = 1'b0; tick(); tick();
      go3 = 1'b1; tick();
      tests_run++;
      if (pending !== 2'b10 || dropped !== 2'b00) begin
         fails++;
         $display("FAIL drop_first_req: pend=%b drop=%b, want 10 00", pending, dropped);
      end
      go3 = 1'b0;
      repeat (4) tick();
      go3 = 1'b1; tick();
      tests_run++;
      if (dropped !== 2'b10 || pending !== 2'b10) begin
         fails++;
         $display("FAIL drop_flag: drop=%b pend=%b, want 10 10", dropped, pending);
      end
      for (int e = 9; e <= 165; e++) begin
         go3 = (e == 40);
         tick();
         if (done[0] && d0_at < 0) d0_at = e;
         if (done[1]) begin
            d1_n++;
            if (d1_a < 0) d1_a = e; else d1_b = e;
         end
      end
      tests_run++;
      if (d0_at != 31 || d1_n != 2 || d1_a != 91 || d1_b != 151) begin
         fails++;
         $display("FAIL drop_strobes: done0@%0d n1=%0d done1@%0d,%0d, want 31 2 91,151", d0_at, d1_n, d1_a, d1_b);
      end
      tests_run++;
      if (dropped !== 2'b10) begin
         fails++;
         $display("FAIL drop_sticky: drop=%b, want 10", dropped);
      end
   endtask

   task automatic test_clear();
      int bad = 0;
      do_reset();
      go2 = 1'b1; tick();
      go2 = 1'b0; tick();
      go3 = 1'b1; tick();
      go3 = 1'b0; tick();
      go3 = 1'b1; tick();
      go3 = 1'b0;
      repeat (14) tick();
      tests_run++;
      if (count !== CW'(12) || dropped !== 2'b10 || pending !== 2'b10) begin
         fails++;
         $display("FAIL clear_setup: cnt=%0d drop=%b pend=%b, want 12 10 10", count, dropped, pending);
      end
      clr = 1'b1; go3 = 1'b1; tick();
      clr = 1'b0;
      tests_run++;
      if (done !== 2'b00 || pending !== 2'b00 || dropped !== 2'b00 || busy !== 1'b0 || count !== '0) begin
         fails++;
         $display("FAIL clear_edge: done=%b pend=%b drop=%b busy=%b cnt=%0d, want 00 00 00 0 0",
                  done, pending, dropped, busy, count);
      end
      repeat (40) begin
         tick();
         if (done !== 2'b00 || pending !== 2'b00 || busy !== 1'b0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         fails++;
         $display("FAIL clear_quiet: %0d cycles with activity, want 0", bad);
      end
      go3 = 1'b0; tick();
      go2 = 1'b1; go3 = 1'b1; tick();
      go2 = 1'b0; go3 = 1'b0; tick();
      tests_run++;
      if (active_ch !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL clear_keeps_rr: act=%b busy=%b, want 1 1", active_ch, busy);
      end
   endtask

   task automatic test_async_reset();
      int bad = 0;
      do_reset();
      go3 = 1'b1; tick();
      go3 = 1'b0; tick();
      repeat (39) tick();
      tests_run++;
      if (count !== CW'(20)) begin
         fails++;
         $display("FAIL areset_setup: cnt=%0d, want 20", count);
      end
      #3 rst = 1'b1;
      #1;
      tests_run++;
      if ({done, busy, pending, active_ch, dropped, count} !== '0) begin
         fails++;
         $display("FAIL areset_immediate: done=%b busy=%b pend=%b act=%b drop=%b cnt=%0d, want all 0",
                  done, busy, pending, active_ch, dropped, count);
      end
      #2 rst = 1'b0;
      repeat (70) begin
         tick();
         if (done !== 2'b00) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         fails++;
         $display("FAIL areset_no_done: %0d strobes, want 0", bad);
      end
      go2 = 1'b1; tick();
      go2 = 1'b0; tick();
      tests_run++;
      if (count !== CW'(29) || busy !== 1'b1) begin
         fails++;
         $display("FAIL areset_regrant: cnt=%0d busy=%b, want 29 1", count, busy);
      end
      repeat (30) tick();
      tests_run++;
      if (done !== 2'b01) begin
         fails++;
         $display("FAIL areset_redone: done=%b, want 01", done);
      end
   endtask

   task automatic test_fairness();
      logic seq [$];
      int   bad = 0;
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         go2 = ((c / 100) % 2) == 0;
         go3 = go2;
         tick();
         if (done == 2'b01) seq.push_back(1'b0);
         if (done == 2'b10) seq.push_back(1'b1);
         if ({done, busy, pending, active_ch, dropped, count} !== {m_done, m_busy, m_pend, m_act, m_drop, m_count()}) bad++;
      end
      go2 = 1'b0; go3 = 1'b0;
      tests_run++;
      if (seq.size() < 10) begin
         fails++;
         $display("FAIL fair_count: %0d strobes, want >= 10", seq.size());
      end else begin
         for (int i = 1; i < 10; i++) if (seq[i] == seq[i-1]) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         fails++;
         $display("FAIL fair_alternate: %0d violations, want 0", bad);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 24) == 0) go2 = ~go2;
         if ($urandom_range(0, 24) == 0) go3 = ~go3;
         clr = ($urandom_range(0, 299) == 0);
         tick();
         tests_run++;
         if ({done, busy, pending, active_ch, dropped, count} !== {m_done, m_busy, m_pend, m_act, m_drop, m_count()}) begin
            fails++;
            $display("FAIL rand_cycle%0d: got done=%b busy=%b pend=%b act=%b drop=%b cnt=%0d, want %b %b %b %b %b %0d",
                     c, done, busy, pending, active_ch, dropped, count,
                     m_done, m_busy, m_pend, m_act, m_drop, m_count());
         end
         if (done == 2'b11) begin
            tests_run++;
            fails++;
            $display("FAIL rand_dual_done: done=%b, want at most one bit", done);
         end
      end
      clr = 1'b0; go2 = 1'b0; go3 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_both();
      test_dropped();
      test_clear();
      test_async_reset();
      test_fairness();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
